// File: rtl/piso_load_shift_ctrl_pkg.sv
// Shared types and elaboration helpers for the PISO load/shift sequencer.
// The FSM state encoding is fixed: IDLE=0, SHIFT=1, DONE=2.
package piso_load_shift_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // The counter must be able to hold the value WIDTH, so size it for WIDTH+1 states.
    function automatic int cnt_width(input int width);
        return clog2(width + 1);
    endfunction

endpackage

// File: rtl/piso_load_shift_ctrl_mux2.sv
// One bit of the shift register's next-value selector.
// Chooses between the parallel word bit and the neighbouring serial bit.
module mux2 (
    input  logic s,
    input  logic serial,
    input  logic parr,
    output logic out
);

    assign out = s ? parr : serial;

endmodule

// File: rtl/piso_load_shift_ctrl.sv
// Parallel-in/serial-out sequencer: accepts a word on a valid/ready port,
// then shifts it out one bit per BAUD_DIV cycles and pulses done.
module piso_load_shift_ctrl
    import piso_load_shift_ctrl_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int BAUD_DIV  = 1,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_LVL  = 1'b1,
    localparam int CNT_W    = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ser_in,
    input  logic             abort,
    output logic             sel,
    output logic             ser_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] bit_cnt,
    output state_t           fsm_state
);

    localparam int BC_W = (clog2(BAUD_DIV) < 1) ? 1 : clog2(BAUD_DIV);
    localparam logic [BC_W-1:0]  BAUD_LAST = BC_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(WIDTH);

    // Handshake: a word transfers on a rising edge where load_valid && load_ready.
    // load_ready is high only in IDLE with no abort; the producer holds data until then.
    state_t            state;
    logic [WIDTH-1:0]  sr;
    logic [WIDTH-1:0]  sr_next;
    logic [WIDTH-1:0]  serial_src;
    logic [BC_W-1:0]   baud_cnt;
    logic              tick;
    logic              accept;

    assign tick       = (state == ST_SHIFT) && (baud_cnt == BAUD_LAST);
    assign load_ready = (state == ST_IDLE) && !abort;
    assign accept     = load_valid && load_ready;
    assign sel        = (state == ST_IDLE);
    assign busy       = (state != ST_IDLE);
    assign done       = (state == ST_DONE);
    assign fsm_state  = state;
    assign ser_out    = (state == ST_SHIFT) ? (MSB_FIRST ? sr[WIDTH-1] : sr[0]) : IDLE_LVL;

    // Shift toward the output end; the fill bit enters at the opposite end.
    generate
        if (MSB_FIRST) begin : g_msb
            assign serial_src = {sr[WIDTH-2:0], ser_in};
        end else begin : g_lsb
            assign serial_src = {ser_in, sr[WIDTH-1:1]};
        end

        for (genvar i = 0; i < WIDTH; i++) begin : g_mux
            mux2 u_mux (
                .s      (sel),
                .serial (serial_src[i]),
                .parr   (load_data[i]),
                .out    (sr_next[i])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            sr       <= '0;
            bit_cnt  <= '0;
            baud_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    baud_cnt <= '0;
                    if (accept) begin
                        sr      <= sr_next;
                        bit_cnt <= '0;
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (abort) begin
                        state    <= ST_IDLE;
                        sr       <= '0;
                        bit_cnt  <= '0;
                        baud_cnt <= '0;
                    end else if (tick) begin
                        sr       <= sr_next;
                        baud_cnt <= '0;
                        if (bit_cnt != FULL_CNT) bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) state <= ST_DONE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    baud_cnt <= '0;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_load_shift_ctrl.sv
// Directed bench: MSB-first/BAUD_DIV=1 instance (a) and LSB-first/BAUD_DIV=3 instance (b).
module tb_piso_load_shift_ctrl;
    import piso_load_shift_ctrl_pkg::*;

    logic       clk;
    logic       rst_n;

    logic       a_load_valid, a_ser_in, a_abort;
    logic [7:0] a_load_data;
    logic       a_load_ready, a_sel, a_ser_out, a_busy, a_done;
    logic [3:0] a_bit_cnt;
    state_t     a_state;

    logic       b_load_valid, b_ser_in, b_abort;
    logic [7:0] b_load_data;
    logic       b_load_ready, b_sel, b_ser_out, b_busy, b_done;
    logic [3:0] b_bit_cnt;
    state_t     b_state;

    int checks = 0;
    int errors = 0;

    piso_load_shift_ctrl #(.WIDTH(8), .BAUD_DIV(1), .MSB_FIRST(1'b1), .IDLE_LVL(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .load_valid(a_load_valid), .load_ready(a_load_ready),
        .load_data(a_load_data), .ser_in(a_ser_in), .abort(a_abort), .sel(a_sel),
        .ser_out(a_ser_out), .busy(a_busy), .done(a_done), .bit_cnt(a_bit_cnt),
        .fsm_state(a_state)
    );

    piso_load_shift_ctrl #(.WIDTH(8), .BAUD_DIV(3), .MSB_FIRST(1'b0), .IDLE_LVL(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .load_valid(b_load_valid), .load_ready(b_load_ready),
        .load_data(b_load_data), .ser_in(b_ser_in), .abort(b_abort), .sel(b_sel),
        .ser_out(b_ser_out), .busy(b_busy), .done(b_done), .bit_cnt(b_bit_cnt),
        .fsm_state(b_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic a_load(input logic [7:0] data);
        a_load_valid = 1'b1;
        a_load_data  = data;
        #1;
        check("a_ready_before_accept", 32'(a_load_ready), 32'd1);
        step();
        a_load_valid = 1'b0;
    endtask

    // Expects the accept edge just passed: eight bit periods, a DONE cycle, then IDLE.
    task automatic a_expect_word(input logic [7:0] data, input string tag);
        for (int k = 0; k < 8; k++) begin
            check({tag, "_ser_out"}, 32'(a_ser_out), 32'(data[7-k]));
            check({tag, "_bit_cnt"}, 32'(a_bit_cnt), 32'(k));
            check({tag, "_ready_low"}, 32'(a_load_ready), 32'd0);
            check({tag, "_sel_low"}, 32'(a_sel), 32'd0);
            step();
        end
        check({tag, "_done_pulse"}, 32'(a_done), 32'd1);
        check({tag, "_done_idle_lvl"}, 32'(a_ser_out), 32'd1);
        check({tag, "_done_cnt"}, 32'(a_bit_cnt), 32'd8);
        check({tag, "_done_ready_low"}, 32'(a_load_ready), 32'd0);
        step();
        check({tag, "_done_cleared"}, 32'(a_done), 32'd0);
        check({tag, "_back_idle"}, 32'(a_state), 32'(ST_IDLE));
        check({tag, "_ready_again"}, 32'(a_load_ready), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        a_load_valid = 1'b0; a_ser_in = 1'b0; a_abort = 1'b0; a_load_data = 8'h00;
        b_load_valid = 1'b0; b_ser_in = 1'b0; b_abort = 1'b0; b_load_data = 8'h00;
        step();
        step();

        // Reset state
        check("rst_state", 32'(a_state), 32'(ST_IDLE));
        check("rst_ser_out", 32'(a_ser_out), 32'd1);
        check("rst_done", 32'(a_done), 32'd0);
        check("rst_busy", 32'(a_busy), 32'd0);
        check("rst_sel", 32'(a_sel), 32'd1);
        check("rst_bit_cnt", 32'(a_bit_cnt), 32'd0);
        check("rst_b_ser_out", 32'(b_ser_out), 32'd1);
        rst_n = 1'b1;
        #1;
        check("rst_ready", 32'(a_load_ready), 32'd1);
        step();

        // MSB-first 8'hA5: 1,0,1,0,0,1,0,1 then done, then ready
        a_load(8'hA5);
        check("a5_state_shift", 32'(a_state), 32'(ST_SHIFT));
        check("a5_busy", 32'(a_busy), 32'd1);
        a_expect_word(8'hA5, "a5");

        // LSB-first, 3 cycles per bit, 8'h01: 1 for 3 cycles then 0 for 21
        b_load_valid = 1'b1;
        b_load_data  = 8'h01;
        step();
        b_load_valid = 1'b0;
        for (int k = 0; k < 24; k++) begin
            check("b01_ser_out", 32'(b_ser_out), (k < 3) ? 32'd1 : 32'd0);
            check("b01_bit_cnt", 32'(b_bit_cnt), 32'(k / 3));
            check("b01_no_done", 32'(b_done), 32'd0);
            step();
        end
        check("b01_done_pulse", 32'(b_done), 32'd1);
        check("b01_done_cnt", 32'(b_bit_cnt), 32'd8);
        step();
        check("b01_done_cleared", 32'(b_done), 32'd0);
        check("b01_ready_again", 32'(b_load_ready), 32'd1);

        // Abort after three bits of 8'hFF
        a_load(8'hFF);
        for (int k = 0; k < 3; k++) begin
            check("ff_ser_out", 32'(a_ser_out), 32'd1);
            step();
        end
        check("ff_bits_sent", 32'(a_bit_cnt), 32'd3);
        a_abort = 1'b1;
        step();
        check("abort_state", 32'(a_state), 32'(ST_IDLE));
        check("abort_bit_cnt", 32'(a_bit_cnt), 32'd0);
        check("abort_no_done", 32'(a_done), 32'd0);
        check("abort_ser_out", 32'(a_ser_out), 32'd1);
        check("abort_ready_blocked", 32'(a_load_ready), 32'd0);
        a_abort = 1'b0;
        #1;
        check("abort_ready_back", 32'(a_load_ready), 32'd1);
        step();
        check("abort_still_no_done", 32'(a_done), 32'd0);
        a_load(8'h0F);
        a_expect_word(8'h0F, "w0f");

        // load_valid held high across two words: one DONE gap, nothing dropped
        a_load_valid = 1'b1;
        a_load_data  = 8'h11;
        #1;
        check("b2b_ready_first", 32'(a_load_ready), 32'd1);
        step();
        a_load_data = 8'h22;
        a_expect_word(8'h11, "w11");
        step();
        a_load_valid = 1'b0;
        check("b2b_second_accepted", 32'(a_state), 32'(ST_SHIFT));
        a_expect_word(8'h22, "w22");

        // abort and load_valid together in IDLE: nothing accepted
        a_abort      = 1'b1;
        a_load_valid = 1'b1;
        a_load_data  = 8'h3C;
        #1;
        check("idle_abort_ready", 32'(a_load_ready), 32'd0);
        check("idle_abort_sel", 32'(a_sel), 32'd1);
        step();
        check("idle_abort_state", 32'(a_state), 32'(ST_IDLE));
        check("idle_abort_sel_after", 32'(a_sel), 32'd1);
        check("idle_abort_busy", 32'(a_busy), 32'd0);
        check("idle_abort_cnt_kept", 32'(a_bit_cnt), 32'd8);
        a_abort      = 1'b0;
        a_load_valid = 1'b0;
        step();

        // Asynchronous reset in the middle of a shift
        a_load(8'hC3);
        step();
        step();
        step();
        check("mid_rst_busy_before", 32'(a_busy), 32'd1);
        check("mid_rst_cnt_before", 32'(a_bit_cnt), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_state", 32'(a_state), 32'(ST_IDLE));
        check("mid_rst_ser_out", 32'(a_ser_out), 32'd1);
        check("mid_rst_done", 32'(a_done), 32'd0);
        check("mid_rst_bit_cnt", 32'(a_bit_cnt), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("mid_rst_no_done", 32'(a_done), 32'd0);
        check("mid_rst_ready", 32'(a_load_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
